// File: rtl/score_arbiter.sv
// Two-requester BCD score accumulator: round-robin grant, nibble-serial decimal add,
// saturation at all nines, and rejection of addends that are not valid BCD.
module score_arbiter #(
  parameter int NUM_NIBBLES    = 6,
  parameter int SCORE_BITWIDTH = 4 * NUM_NIBBLES
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [1:0]                req,
  input  logic [7:0]                addValue0,
  input  logic [7:0]                addValue1,
  output logic [1:0]                grant,
  output logic [1:0]                ack,
  output logic                      error,
  output logic                      busy,
  output logic                      saturated,
  output logic [SCORE_BITWIDTH-1:0] countValueOut
);

  localparam int IDX_W = (NUM_NIBBLES > 1) ? $clog2(NUM_NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, ADD, COMMIT, REJECT} state_t;

  state_t                    state_reg, state_next;
  logic [1:0]                grant_reg, grant_next;
  logic [1:0]                ack_reg, ack_next;
  logic                      error_reg, error_next;
  logic [SCORE_BITWIDTH-1:0] score_reg, score_next;
  logic [SCORE_BITWIDTH-1:0] work_reg, work_next;
  logic [SCORE_BITWIDTH-1:0] addend_reg, addend_next;
  logic [IDX_W-1:0]          idx_reg, idx_next;
  logic                      carry_reg, carry_next;
  logic                      rr_ptr_reg, rr_ptr_next;

  logic [1:0]                eligible;
  logic                      sel;
  logic [7:0]                sel_value;
  logic                      sel_invalid;
  logic [3:0]                work_nib, addend_nib;
  logic [4:0]                nibble_sum, nibble_adj;
  logic [SCORE_BITWIDTH-1:0] all_nines;
  logic [NUM_NIBBLES-1:0]    nib_is_nine;

  generate
    for (genvar gi = 0; gi < NUM_NIBBLES; gi++) begin : g_nines
      assign all_nines[gi*4 +: 4] = 4'd9;
      assign nib_is_nine[gi]      = (score_reg[gi*4 +: 4] == 4'd9);
    end
  endgenerate

  // A requester whose ack is showing this cycle is not eligible, so it can drop req safely.
  always_comb begin
    eligible    = req & ~ack_reg;
    sel         = (eligible == 2'b11) ? rr_ptr_reg : eligible[1];
    sel_value   = sel ? addValue1 : addValue0;
    sel_invalid = (sel_value[7:4] > 4'd9) || (sel_value[3:0] > 4'd9);
    work_nib    = work_reg[idx_reg*4 +: 4];
    addend_nib  = addend_reg[idx_reg*4 +: 4];
    nibble_sum  = {1'b0, work_nib} + {1'b0, addend_nib} + {4'b0, carry_reg};
    nibble_adj  = nibble_sum - 5'd10;
  end

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    ack_next    = 2'b00;
    error_next  = 1'b0;
    score_next  = score_reg;
    work_next   = work_reg;
    addend_next = addend_reg;
    idx_next    = idx_reg;
    carry_next  = carry_reg;
    rr_ptr_next = rr_ptr_reg;
    if (clear) begin
      state_next = IDLE;
      grant_next = 2'b00;
      score_next = '0;
      work_next  = '0;
      idx_next   = '0;
      carry_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (eligible != 2'b00) begin
            grant_next  = sel ? 2'b10 : 2'b01;
            rr_ptr_next = ~sel;
            addend_next = SCORE_BITWIDTH'(sel_value);
            work_next   = score_reg;
            idx_next    = '0;
            carry_next  = 1'b0;
            state_next  = sel_invalid ? REJECT : ADD;
          end
        end
        ADD: begin
          carry_next = (nibble_sum > 5'd9);
          work_next[idx_reg*4 +: 4] = (nibble_sum > 5'd9) ? nibble_adj[3:0] : nibble_sum[3:0];
          if (idx_reg == LAST_IDX) state_next = COMMIT;
          else                     idx_next   = idx_reg + 1'b1;
        end
        COMMIT: begin
          score_next = carry_reg ? all_nines : work_reg;
          ack_next   = grant_reg;
          grant_next = 2'b00;
          state_next = IDLE;
        end
        REJECT: begin
          // Held for two cycles; idx_reg marks the second one.
          if (idx_reg == '0) begin
            idx_next = IDX_W'(1);
          end else begin
            ack_next   = grant_reg;
            error_next = 1'b1;
            grant_next = 2'b00;
            idx_next   = '0;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= IDLE;
      grant_reg  <= 2'b00;
      ack_reg    <= 2'b00;
      error_reg  <= 1'b0;
      score_reg  <= '0;
      work_reg   <= '0;
      addend_reg <= '0;
      idx_reg    <= '0;
      carry_reg  <= 1'b0;
      rr_ptr_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      ack_reg    <= ack_next;
      error_reg  <= error_next;
      score_reg  <= score_next;
      work_reg   <= work_next;
      addend_reg <= addend_next;
      idx_reg    <= idx_next;
      carry_reg  <= carry_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  assign grant         = grant_reg;
  assign ack           = ack_reg;
  assign error         = error_reg;
  assign busy          = (state_reg != IDLE);
  assign saturated     = &nib_is_nine;
  assign countValueOut = score_reg;

endmodule

// File: tb/tb_score_arbiter.sv
// Scoreboard bench for score_arbiter: a decimal model predicts each ack, a negedge monitor compares.
module tb_score_arbiter;

  logic        clock = 1'b0;
  logic        reset, clear;
  logic [1:0]  req;
  logic [7:0]  addValue0, addValue1;
  logic [1:0]  grant, ack;
  logic        error, busy, saturated;
  logic [23:0] countValueOut;

  logic        clear2;
  logic [1:0]  req2;
  logic [7:0]  a0_2, a1_2;
  logic [1:0]  grant2, ack2;
  logic        error2, busy2, sat2;
  logic [7:0]  count2;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0]  ack;
    logic        err;
    logic [23:0] score;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  logic [23:0] model_score;

  score_arbiter dut (
    .clock(clock), .reset(reset), .clear(clear), .req(req),
    .addValue0(addValue0), .addValue1(addValue1),
    .grant(grant), .ack(ack), .error(error), .busy(busy),
    .saturated(saturated), .countValueOut(countValueOut)
  );

  score_arbiter #(.NUM_NIBBLES(2)) dut2 (
    .clock(clock), .reset(reset), .clear(clear2), .req(req2),
    .addValue0(a0_2), .addValue1(a1_2),
    .grant(grant2), .ack(ack2), .error(error2), .busy(busy2),
    .saturated(sat2), .countValueOut(count2)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int bcd2int(input logic [23:0] v);
    int r = 0;
    for (int i = 5; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [23:0] int2bcd(input int n);
    logic [23:0] r;
    int t = n;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit bcd_bad(input logic [7:0] val);
    return (val[7:4] > 4'd9) || (val[3:0] > 4'd9);
  endfunction

  task automatic push_exp(input int who, input logic [7:0] val, input int due);
    exp_t e;
    int   s;
    if (!bcd_bad(val)) begin
      s = bcd2int(model_score) + int'(val[7:4]) * 10 + int'(val[3:0]);
      if (s > 999999) s = 999999;
      model_score = int2bcd(s);
    end
    e.ack   = 2'(1 << who);
    e.err   = bcd_bad(val);
    e.score = model_score;
    e.due   = due;
    sb_q.push_back(e);
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (sb_q.size() != 0 && cyc > sb_q[0].due) begin
      e = sb_q.pop_front();
      check_val("ack_missing", 32'(ack), 32'(e.ack));
    end else if (ack != 2'b00 || error) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_ack", {29'd0, ack, error}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        $display("[TB] cyc=%0d ack=%b error=%b score=%h", cyc, ack, error, countValueOut);
        check_val("ack", 32'(ack), 32'(e.ack));
        check_val("error", 32'(error), 32'(e.err));
        check_val("score", 32'(countValueOut), 32'(e.score));
        check_val("latency", 32'(cyc), 32'(e.due));
        check_val("saturated", 32'(saturated), 32'(e.score == 24'h999999));
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) begin
      @(negedge clock);
      #1;
    end
    if (sb_q.size() != 0) begin
      check_val("drain_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic do_add(input int who, input logic [7:0] val);
    int lat;
    lat = bcd_bad(val) ? 2 : 7;
    @(negedge clock);
    req = 2'(1 << who);
    if (who == 0) addValue0 = val;
    else          addValue1 = val;
    push_exp(who, val, cyc + 1 + lat);
    @(negedge clock);
    check_val("grant", 32'(grant), 32'(1 << who));
    req       = 2'b00;
    addValue0 = 8'($urandom);
    addValue1 = 8'($urandom);
    wait_drain();
  endtask

  task automatic do_add2(input int who, input logic [7:0] val, input logic [7:0] exp_score,
                         input logic exp_err, input int exp_lat);
    int c0;
    @(negedge clock);
    req2 = 2'(1 << who);
    if (who == 0) a0_2 = val;
    else          a1_2 = val;
    c0 = cyc;
    @(negedge clock);
    req2 = 2'b00;
    for (int i = 0; i < 20 && ack2 == 2'b00; i++) @(negedge clock);
    $display("[TB] dut2 cyc=%0d ack=%b error=%b score=%h", cyc, ack2, error2, count2);
    check_val("dut2_ack", 32'(ack2), 32'(1 << who));
    check_val("dut2_error", 32'(error2), 32'(exp_err));
    check_val("dut2_score", 32'(count2), 32'(exp_score));
    check_val("dut2_latency", 32'(cyc - c0 - 1), 32'(exp_lat));
    check_val("dut2_saturated", 32'(sat2), 32'(exp_score == 8'h99));
  endtask

  task automatic check_idle_zero(input string tag);
    check_val({tag, "_grant"}, 32'(grant), 32'd0);
    check_val({tag, "_ack"}, 32'(ack), 32'd0);
    check_val({tag, "_error"}, 32'(error), 32'd0);
    check_val({tag, "_busy"}, 32'(busy), 32'd0);
    check_val({tag, "_saturated"}, 32'(saturated), 32'd0);
    check_val({tag, "_score"}, 32'(countValueOut), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got still running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset = 1'b1; clear = 1'b0; req = 2'b00; addValue0 = 8'h00; addValue1 = 8'h00;
    clear2 = 1'b0; req2 = 2'b00; a0_2 = 8'h00; a1_2 = 8'h00;
    model_score = 24'h0;
    repeat (3) @(negedge clock);
    check_idle_zero("reset");
    check_val("reset_dut2_score", 32'(count2), 32'd0);
    reset = 1'b0;

    do_add(0, 8'h25);

    @(negedge clock) clear = 1'b1;
    @(negedge clock) clear = 1'b0;
    check_val("clear_score", 32'(countValueOut), 32'd0);
    model_score = 24'h0;

    for (int i = 0; i < 101; i++) do_add(0, 8'h99);
    do_add(1, 8'h01);
    do_add(0, 8'h1A);
    do_add(1, 8'hA1);

    // Clear lands during the third ADD cycle; no ack may follow.
    @(negedge clock);
    req = 2'b01; addValue0 = 8'h05;
    @(negedge clock) req = 2'b00;
    @(negedge clock);
    @(negedge clock) clear = 1'b1;
    @(negedge clock) clear = 1'b0;
    check_val("abort_score", 32'(countValueOut), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_grant", 32'(grant), 32'd0);
    model_score = 24'h0;
    repeat (10) @(negedge clock);

    @(negedge clock);
    req = 2'b01; clear = 1'b1;
    @(negedge clock);
    check_val("clear_wins_grant", 32'(grant), 32'd0);
    check_val("clear_wins_busy", 32'(busy), 32'd0);
    req = 2'b00; clear = 1'b0;

    do_add(1, 8'h42);

    do_add2(0, 8'h90, 8'h90, 1'b0, 3);
    do_add2(0, 8'h15, 8'h99, 1'b0, 3);
    do_add2(1, 8'h1A, 8'h99, 1'b1, 2);

    // Reset in the middle of ADD aborts without ack.
    @(negedge clock);
    req = 2'b10; addValue1 = 8'h33;
    @(negedge clock) req = 2'b00;
    @(negedge clock);
    @(negedge clock) reset = 1'b1;
    @(negedge clock);
    check_idle_zero("reset_mid");
    reset = 1'b0;
    model_score = 24'h0;
    repeat (10) @(negedge clock);

    @(negedge clock);
    req = 2'b11; addValue0 = 8'h01; addValue1 = 8'h02;
    c = cyc;
    push_exp(0, 8'h01, c + 1 + 7);
    push_exp(1, 8'h02, c + 1 + 15);
    @(negedge clock);
    check_val("rr_grant_first", 32'(grant), 32'd1);
    for (int i = 0; i < 20 && grant != 2'b10; i++) @(negedge clock);
    check_val("rr_grant_second", 32'(grant), 32'd2);
    check_val("rr_grant_cycle", 32'(cyc - c), 32'd9);
    req = 2'b00;
    wait_drain();
    check_val("rr_final_score", 32'(countValueOut), 32'h3);

    repeat (5) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
